// File: rtl/quantizer_pipe_pkg.sv
// Shared fixed-point definitions for the quantizer pipeline.
// Round-mode encodings and small elaboration helpers.
package quantizer_pipe_pkg;

  typedef enum logic [1:0] {
    RM_TRUNC     = 2'd0,
    RM_HALF_UP   = 2'd1,
    RM_HALF_EVEN = 2'd2
  } round_mode_e;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/qz_channel.sv
// One quantiser lane: stage 1 aligns and rounds, stage 2 saturates.
// Intermediate width keeps a round-up carry visible to the clamp.
module qz_channel
  import quantizer_pipe_pkg::*;
#(
  parameter int NB_XI   = 20,
  parameter int NBF_XI  = 12,
  parameter int NB_XO   = 8,
  parameter int NBF_XO  = 6,
  parameter int SYM_SAT = 0
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_en1,
  input  logic             i_en2,
  input  logic [NB_XI-1:0] i_data,
  input  logic [1:0]       i_round_mode,
  output logic [NB_XO-1:0] o_data,
  output logic             o_sat
);

  localparam int D  = (NBF_XI > NBF_XO) ? NBF_XI - NBF_XO : 0;
  localparam int P  = (NBF_XO > NBF_XI) ? NBF_XO - NBF_XI : 0;
  localparam int WW = max_i(NB_XI + 1 + P, NB_XO + 1);

  localparam logic signed [WW-1:0] MAXV = WW'((1 << (NB_XO - 1)) - 1);
  localparam logic signed [WW-1:0] MINV =
    (SYM_SAT != 0) ? -MAXV : -MAXV - WW'(1);

  logic signed [WW-1:0] x_ext;
  logic signed [WW-1:0] r_d, r_q;
  logic [NB_XO-1:0]     data_d, data_q;
  logic                 sat_d, sat_q;

  assign x_ext = {{(WW - NB_XI){i_data[NB_XI-1]}}, i_data};

  if (D > 0) begin : g_rnd
    localparam logic signed [WW-1:0] HALF = WW'(1 << (D - 1));
    localparam logic [D-1:0] HALF_PAT = D'(1 << (D - 1));
    logic signed [WW-1:0] inc;

    always_comb begin
      inc = '0;
      unique case (i_round_mode)
        RM_HALF_UP: inc = HALF;
        RM_HALF_EVEN: begin
          // exact tie with even kept LSB stays put
          if (!(x_ext[D-1:0] == HALF_PAT && !x_ext[D]))
            inc = HALF;
        end
        default: inc = '0;
      endcase
    end

    assign r_d = (x_ext + inc) >>> D;
  end else if (P > 0) begin : g_pad
    assign r_d = x_ext <<< P;
  end else begin : g_pass
    assign r_d = x_ext;
  end

  always_ff @(posedge clk) begin
    if (i_reset)    r_q <= '0;
    else if (i_en1) r_q <= r_d;
  end

  always_comb begin
    sat_d  = 1'b0;
    data_d = r_q[NB_XO-1:0];
    if (r_q > MAXV) begin
      sat_d  = 1'b1;
      data_d = MAXV[NB_XO-1:0];
    end else if (r_q < MINV) begin
      sat_d  = 1'b1;
      data_d = MINV[NB_XO-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      data_q <= '0;
      sat_q  <= 1'b0;
    end else if (i_en2) begin
      data_q <= data_d;
      sat_q  <= sat_d;
    end
  end

  assign o_data = data_q;
  assign o_sat  = sat_q;

endmodule

// File: rtl/quantizer_pipe.sv
// Multi-channel fixed-point requantiser, two-cycle latency.
// Holds stage valids and the sticky saturation-event counter.
module quantizer_pipe
  import quantizer_pipe_pkg::*;
#(
  parameter int NB_XI   = 20,
  parameter int NBF_XI  = 12,
  parameter int NB_XO   = 8,
  parameter int NBF_XO  = 6,
  parameter int N_CH    = 4,
  parameter int SYM_SAT = 0,
  parameter int NB_CNT  = 16
) (
  input  logic                    clk,
  input  logic                    i_reset,
  input  logic                    i_valid,
  input  logic [N_CH*NB_XI-1:0]   i_data,
  input  logic [1:0]              i_round_mode,
  input  logic                    i_clr_cnt,
  output logic                    o_valid,
  output logic [N_CH*NB_XO-1:0]   o_data,
  output logic [N_CH-1:0]         o_sat,
  output logic [NB_CNT-1:0]       o_sat_count
);

  logic              v1_q, v2_q;
  logic [NB_CNT-1:0] cnt_d, cnt_q;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= i_valid;
      v2_q <= v1_q;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    qz_channel #(
      .NB_XI  (NB_XI),
      .NBF_XI (NBF_XI),
      .NB_XO  (NB_XO),
      .NBF_XO (NBF_XO),
      .SYM_SAT(SYM_SAT)
    ) u_ch (
      .clk         (clk),
      .i_reset     (i_reset),
      .i_en1       (i_valid),
      .i_en2       (v1_q),
      .i_data      (i_data[k*NB_XI +: NB_XI]),
      .i_round_mode(i_round_mode),
      .o_data      (o_data[k*NB_XO +: NB_XO]),
      .o_sat       (o_sat[k])
    );
  end

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr_cnt)
      cnt_d = '0;
    else if (v2_q && (|o_sat) && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign o_valid     = v2_q;
  assign o_sat_count = cnt_q;

endmodule
